// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I opcode constants and decode helpers
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // addi x0,x0,0: decodes as a harmless I-type ALU op
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // True for every opcode the multicycle core implements
  function automatic logic is_legal_op(input logic [6:0] op);
    logic legal;
    case (op)
      OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE, OP_R,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: legal = 1'b1;
      default:                            legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/en_reg.sv
// rtl/en_reg.sv - enable-gated register with asynchronous active-high reset
module en_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load d when enabled, otherwise hold; reset wins immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/datapath_regs.sv
// rtl/datapath_regs.sv - non-architectural register bank of the multicycle core
module datapath_regs
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IRWrite,
  input  logic             PCWrite,
  input  logic [XLEN-1:0]  ReadData,
  input  logic [XLEN-1:0]  PCNext,
  input  logic [XLEN-1:0]  RD1,
  input  logic [XLEN-1:0]  RD2,
  input  logic [XLEN-1:0]  ALUResult,
  output logic [XLEN-1:0]  PC,
  output logic [XLEN-1:0]  OldPC,
  output logic [XLEN-1:0]  Instr,
  output logic [6:0]       op,
  output logic [2:0]       funct3,
  output logic             funct7b5,
  output logic [XLEN-1:0]  Data,
  output logic [XLEN-1:0]  A,
  output logic [XLEN-1:0]  WriteData,
  output logic [XLEN-1:0]  ALUOut,
  output logic             illegal_op,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [XLEN-1:0]  INSTR_RST = XLEN'(NOP_INSTR);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // PC only moves when control_unit asks for it
  en_reg #(.W(XLEN), .RST_VAL(RESET_PC)) u_pc (
    .clk (clk),
    .rst (rst),
    .en  (PCWrite),
    .d   (PCNext),
    .q   (PC)
  );

  // OldPC samples the pre-edge PC together with the instruction fetch, so
  // during a combined fetch it records the fetched instruction's address,
  // not the incremented PC arriving on PCNext
  en_reg #(.W(XLEN), .RST_VAL(RESET_PC)) u_oldpc (
    .clk (clk),
    .rst (rst),
    .en  (IRWrite),
    .d   (PC),
    .q   (OldPC)
  );

  en_reg #(.W(XLEN), .RST_VAL(INSTR_RST)) u_instr (
    .clk (clk),
    .rst (rst),
    .en  (IRWrite),
    .d   (ReadData),
    .q   (Instr)
  );

  // Decode fields come straight off the latched instruction
  assign op       = Instr[6:0];
  assign funct3   = Instr[14:12];
  assign funct7b5 = Instr[30];

  // Pipeline registers between FSM states load every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Data      <= '0;
      A         <= '0;
      WriteData <= '0;
      ALUOut    <= '0;
    end else begin
      Data      <= ReadData;
      A         <= RD1;
      WriteData <= RD2;
      ALUOut    <= ALUResult;
    end
  end

  // Sticky flag raised on the same edge the bad instruction enters IR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_op <= 1'b0;
    end else if (IRWrite && !is_legal_op(ReadData[6:0])) begin
      illegal_op <= 1'b1;
    end
  end

  // Free-running counters; overflow wraps silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count <= '0;
      fetch_count <= '0;
    end else begin
      cycle_count <= cycle_count + CNT_ONE;
      if (IRWrite) begin
        fetch_count <= fetch_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_datapath_regs.sv
// tb/tb_datapath_regs.sv - directed scoreboard bench for datapath_regs
module tb_datapath_regs;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] oldpc;
    logic [31:0] instr;
    logic [31:0] data;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] alu;
    logic        ill;
    logic [3:0]  cyc;
    logic [3:0]  fch;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        IRWrite, PCWrite;
  logic [31:0] ReadData, PCNext, RD1, RD2, ALUResult;
  logic [31:0] PC, OldPC, Instr, Data, A, WriteData, ALUOut;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        illegal_op;
  logic [3:0]  cycle_count, fetch_count;

  int   total = 0;
  int   bad   = 0;
  exp_t m;
  exp_t sb[$];

  always #5 clk = ~clk;

  datapath_regs #(.XLEN(32), .RESET_PC(32'h100), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .IRWrite     (IRWrite),
    .PCWrite     (PCWrite),
    .ReadData    (ReadData),
    .PCNext      (PCNext),
    .RD1         (RD1),
    .RD2         (RD2),
    .ALUResult   (ALUResult),
    .PC          (PC),
    .OldPC       (OldPC),
    .Instr       (Instr),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .Data        (Data),
    .A           (A),
    .WriteData   (WriteData),
    .ALUOut      (ALUOut),
    .illegal_op  (illegal_op),
    .cycle_count (cycle_count),
    .fetch_count (fetch_count)
  );

  function automatic bit legal(input logic [6:0] o);
    return o inside {7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m.pc = 32'h100; m.oldpc = 32'h100; m.instr = 32'h13;
    m.data = '0; m.a = '0; m.wd = '0; m.alu = '0;
    m.ill = 1'b0; m.cyc = '0; m.fch = '0;
    sb.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pc"},    PC, 32'h100);
    chk({tag, "_oldpc"}, OldPC, 32'h100);
    chk({tag, "_instr"}, Instr, 32'h13);
    chk({tag, "_op"},    {25'd0, op}, 32'h13);
    chk({tag, "_data"},  Data, 32'h0);
    chk({tag, "_alu"},   ALUOut, 32'h0);
    chk({tag, "_ill"},   {31'd0, illegal_op}, 32'h0);
    chk({tag, "_cyc"},   {28'd0, cycle_count}, 32'h0);
    chk({tag, "_fch"},   {28'd0, fetch_count}, 32'h0);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_pc"},    PC, e.pc);
      chk({tag, "_oldpc"}, OldPC, e.oldpc);
      chk({tag, "_instr"}, Instr, e.instr);
      chk({tag, "_op"},    {25'd0, op}, {25'd0, e.instr[6:0]});
      chk({tag, "_f3"},    {29'd0, funct3}, {29'd0, e.instr[14:12]});
      chk({tag, "_f7b5"},  {31'd0, funct7b5}, {31'd0, e.instr[30]});
      chk({tag, "_data"},  Data, e.data);
      chk({tag, "_a"},     A, e.a);
      chk({tag, "_wd"},    WriteData, e.wd);
      chk({tag, "_alu"},   ALUOut, e.alu);
      chk({tag, "_ill"},   {31'd0, illegal_op}, {31'd0, e.ill});
      chk({tag, "_cyc"},   {28'd0, cycle_count}, {28'd0, e.cyc});
      chk({tag, "_fch"},   {28'd0, fetch_count}, {28'd0, e.fch});
    end
  endtask

  // Drive one cycle of stimulus, predict the post-edge state, then compare
  task automatic step(input string tag, input logic irw, input logic pcw,
                      input logic [31:0] rd, input logic [31:0] pcn,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic [31:0] alu);
    exp_t n;
    IRWrite = irw; PCWrite = pcw; ReadData = rd; PCNext = pcn;
    RD1 = r1; RD2 = r2; ALUResult = alu;
    n = m;
    if (irw) begin
      n.instr = rd;
      n.oldpc = m.pc;
      n.fch   = m.fch + 4'd1;
      if (!legal(rd[6:0])) n.ill = 1'b1;
    end
    if (pcw) n.pc = pcn;
    n.data = rd; n.a = r1; n.wd = r2; n.alu = alu;
    n.cyc = m.cyc + 4'd1;
    m = n;
    sb.push_back(n);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  initial begin
    rst = 1'b1;
    IRWrite = 0; PCWrite = 0; ReadData = 0; PCNext = 0;
    RD1 = 0; RD2 = 0; ALUResult = 0;
    model_reset();
    #1;
    check_reset_vals("rst0");
    @(posedge clk);
    #1;
    check_reset_vals("rst0_hold");
    rst = 1'b0;

    step("pass", 0, 0, 32'h1234, 32'h0, 32'h5, 32'h7, 32'hFFFF_FFFE);
    chk("first_cyc", {28'd0, cycle_count}, 32'h1);
    chk("pass_a", A, 32'h5);
    chk("pass_wd", WriteData, 32'h7);
    chk("pass_alu", ALUOut, 32'hFFFF_FFFE);
    chk("pass_data", Data, 32'h1234);
    chk("pass_instr_hold", Instr, 32'h13);

    step("setpc", 0, 1, 32'h0, 32'h8, 32'h0, 32'h0, 32'h0);
    chk("setpc_pc", PC, 32'h8);

    step("fetch", 1, 1, 32'h00A2_8293, 32'hC, 32'h1, 32'h2, 32'h3);
    chk("fetch_instr", Instr, 32'h00A2_8293);
    chk("fetch_oldpc", OldPC, 32'h8);
    chk("fetch_pc", PC, 32'hC);
    chk("fetch_f3", {29'd0, funct3}, 32'h0);
    chk("fetch_fch", {28'd0, fetch_count}, 32'h1);

    step("pconly", 0, 1, 32'hDEAD_BEEF, 32'h40, 32'h9, 32'hA, 32'hB);
    chk("pconly_pc", PC, 32'h40);
    chk("pconly_instr", Instr, 32'h00A2_8293);
    chk("pconly_oldpc", OldPC, 32'h8);
    chk("pconly_op_not_rd", {25'd0, op}, 32'h13);

    step("illegal", 1, 0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("illegal_flag", {31'd0, illegal_op}, 32'h1);
    chk("illegal_instr", Instr, 32'hFFFF_FFFF);
    chk("illegal_oldpc", OldPC, 32'h40);

    step("legal_after", 1, 1, 32'h0000_0033, 32'h44, 32'h0, 32'h0, 32'h0);
    chk("sticky_ill", {31'd0, illegal_op}, 32'h1);
    step("idle", 0, 0, 32'h0000_0063, 32'h0, 32'h11, 32'h22, 32'h33);

    // Asynchronous reset in the middle of a cycle, well away from any edge
    IRWrite = 1; PCWrite = 1; ReadData = 32'h7F; PCNext = 32'h88;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_vals("rst_mid");
    @(posedge clk);
    #1;
    check_reset_vals("rst_mid_hold");
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step("wrap", 1, 1, 32'h0000_0013, 32'h200 + 32'(i * 4), 32'(i), 32'(i + 1), 32'(i + 2));
    end
    chk("wrap_cyc", {28'd0, cycle_count}, 32'h0);
    chk("wrap_fch", {28'd0, fetch_count}, 32'h0);
    chk("wrap_oldpc", OldPC, 32'h238);
    chk("wrap_ill", {31'd0, illegal_op}, 32'h0);

    step("post_wrap", 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("post_wrap_cyc", {28'd0, cycle_count}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/datapath_regs.md
# datapath_regs

Non-architectural register bank of the multicycle core. It latches memory read data into the instruction and data registers, holds PC and OldPC, and pipelines the register-file and ALU outputs across FSM states. It sits directly upstream of control_unit, supplying `op`, `funct3` and `funct7b5` from the latched instruction and consuming its `IRWrite` and `PCWrite` strobes. It also keeps a sticky illegal-opcode flag plus free-running cycle and fetch counters for the bench and later CSR work.

## Interface
- `XLEN`, default 32: datapath width.
- `RESET_PC`, default 32'h0000_0000: PC and OldPC value after reset.
- `CNT_W`, default 64: width of the cycle and fetch counters.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `IRWrite`  in  1  from control_unit: load instruction register.
- `PCWrite`  in  1  from control_unit: load PC.
- `ReadData`  in  XLEN  memory read data.
- `PCNext`  in  XLEN  result bus value to load into PC.
- `RD1`, `RD2`  in  XLEN  register-file read ports.
- `ALUResult`  in  XLEN  ALU output.
- `PC`, `OldPC`  out  XLEN  current PC and PC of the instruction in IR.
- `Instr`  out  XLEN  instruction register.
- `op`  out  7  `Instr[6:0]`.
- `funct3`  out  3  `Instr[14:12]`.
- `funct7b5`  out  1  `Instr[30]`.
- `Data`  out  XLEN  data register.
- `A`  out  XLEN  registered RD1.
- `WriteData`  out  XLEN  registered RD2.
- `ALUOut`  out  XLEN  registered ALUResult.
- `illegal_op`  out  1  sticky: an unsupported opcode was loaded into IR.
- `cycle_count`  out  CNT_W  cycles since reset.
- `fetch_count`  out  CNT_W  IRWrite strobes since reset.

## Operation
- `IRWrite`=1: `Instr`<=`ReadData`, and `OldPC`<=`PC` (the pre-edge value). Otherwise both hold.
- `PCWrite`=1: `PC`<=`PCNext`. Otherwise hold.
- `IRWrite` and `PCWrite` both high (fetch state):
  - `OldPC` captures the old PC, never `PCNext`.
  - `PC` takes `PCNext`.
  - `Instr` takes `ReadData`.
- `Data`, `A`, `WriteData` and `ALUOut` load their inputs unconditionally every cycle.
- `op`, `funct3` and `funct7b5` are pure slices of `Instr`, with no extra register.
- Legal opcodes: 0000011, 0010011, 0010111, 0100011, 0110011, 0110111, 1100011, 1100111, 1101111.
- `illegal_op` is set on the edge where `IRWrite`=1 and `ReadData[6:0]` is not a legal opcode. It therefore becomes visible in the same cycle as the offending `Instr`. It clears only on `rst`.
- `cycle_count` increments every cycle.
- `fetch_count` increments on every edge with `IRWrite`=1.
- Both counters wrap from all-ones to 0 with no flag.

## Timing
- Reset values, applied asynchronously while `rst`=1:
  - `PC` = `OldPC` = `RESET_PC`.
  - `Instr` = 32'h0000_0013 (addi x0,x0,0), so `op`=0010011 and decode is benign.
  - `Data`, `A`, `WriteData`, `ALUOut` = 0.
  - `illegal_op` = 0.
  - Both counters = 0.
- Reset asserted mid-instruction: all state returns to the reset values immediately. No partial update survives.
- First rising edge after `rst` deasserts: `cycle_count` becomes 1.
- Latency: every register output reflects its input one edge after capture, with no combinational path from input to registered output.
- `op`, `funct3` and `funct7b5` are combinational from `Instr` only, never from `ReadData`.
- Strobes are level-sampled per edge. Holding `IRWrite` high for N cycles adds N to `fetch_count` and reloads `OldPC` each cycle.

## Structure
- Shared package `riscv_pkg` holds:
  - opcode localparams: `OP_LOAD`, `OP_IMM`, `OP_AUIPC`, `OP_STORE`, `OP_R`, `OP_LUI`, `OP_BRANCH`, `OP_JALR`, `OP_JAL`;
  - `NOP_INSTR` = 32'h0000_0013;
  - the function `is_legal_op(logic [6:0])`, reused by the decoders.
- Sub-module `en_reg`: parameterized width and reset value, enable-gated flop with async active-high reset. Instantiate it for PC, OldPC and Instr.
- `Data`, `A`, `WriteData` and `ALUOut` are plain always-enabled flops.

## Test plan
- **Reset:** assert `rst` mid-run with `RESET_PC`=32'h100 -> `PC`=`OldPC`=32'h100, `Instr`=32'h13, `op`=7'b0010011, `illegal_op`=0, both counters=0, all without waiting for a clock edge.
- **Fetch:** `PC`=32'h8, `IRWrite`=`PCWrite`=1, `ReadData`=32'h00A28293, `PCNext`=32'hC -> next cycle `Instr`=32'h00A28293, `OldPC`=32'h8, `PC`=32'hC, `funct3`=0, `fetch_count`+1.
- **Independent PC update:** `PCWrite`=1, `IRWrite`=0, `PCNext`=32'h40 -> `PC`=32'h40 with `Instr` and `OldPC` unchanged.
- **Illegal opcode:** load `ReadData`=32'hFFFFFFFF with `IRWrite`=1 -> `illegal_op`=1 in the same cycle as the new `Instr`. Then load a legal 32'h00000033 -> `illegal_op` stays 1 until `rst`.
- **Pass-through registers:** drive `RD1`=32'h5, `RD2`=32'h7, `ALUResult`=32'hFFFF_FFFE, `ReadData`=32'h1234 for one cycle -> next cycle `A`=5, `WriteData`=7, `ALUOut`=32'hFFFF_FFFE, `Data`=32'h1234.
- **Counter wrap:** with `CNT_W`=4, run 16 cycles holding `IRWrite`=1 -> both counters read 0.
